pcie_ss_axis_rx_len_check: RTL and testbench

//  Per-TLP length checker and repair stage on the PCIe SS RX in-band AXI-S path. Sits directly downstream of
//  the RX split / segment-align stage, which delivers at most one header per beat, with the header in the
//  SOP beat. Counts payload beats against the header length field. Passes well-formed TLPs unchanged at full

---
 rtl/pcie_ss_axis_rx_len_check_pkg.sv | 25 ++
 rtl/pcie_ss_axis_rx_len_check_if.sv | 15 +
 rtl/pcie_ss_axis_rx_skid.sv | 46 ++++
 rtl/pcie_ss_axis_rx_len_check.sv | 137 +++++++++++++
 tb/tb_pcie_ss_axis_rx_len_check.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_ss_axis_rx_len_check_pkg.sv
// rtl/pcie_ss_axis_rx_len_check_pkg.sv - shared constants, state type and beat-count helper for the RX length checker
package pcie_ss_rx_len_pkg;

  localparam int HDR_BYTES    = 32;
  localparam int LEN_LSB      = 0;
  localparam int LEN_MSB      = 9;
  localparam int FMT_DATA_BIT = 30;

  typedef enum logic [1:0] {
    SOP     = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } t_len_state;

  // len==0 with data encodes a 1024-DW (4 KiB) payload; result is 1..129 beats
  function automatic logic [7:0] exp_beats(input logic [9:0] len, input logic has_data,
                                           input int data_width);
    int pay_bytes;
    int beat_bytes;
    pay_bytes  = !has_data ? 0 : ((len == 10'd0) ? 4096 : int'(len) * 4);
    beat_bytes = data_width / 8;
    return 8'((HDR_BYTES + pay_bytes + beat_bytes - 1) / beat_bytes);
  endfunction

endpackage

// File: rtl/pcie_ss_axis_rx_len_check_if.sv
// rtl/pcie_ss_axis_rx_len_check_if.sv - AXI-S beat bundle with master/slave views
interface pcie_ss_axis_rx_len_check_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int TUSER_WIDTH = 10
);
  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic [TUSER_WIDTH-1:0]    tuser;
  logic                      tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/pcie_ss_axis_rx_skid.sv
// rtl/pcie_ss_axis_rx_skid.sv - 2-entry registered skid buffer for an opaque AXI-S payload
module pcie_ss_axis_rx_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;

  // The skid entry only fills when the output register is stalled, so readiness never depends on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= in_data;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/pcie_ss_axis_rx_len_check.sv
// rtl/pcie_ss_axis_rx_len_check.sv - per-TLP beat-count checker: passes good TLPs, truncates long ones, flags short ones
module pcie_ss_axis_rx_len_check
  import pcie_ss_rx_len_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcie_ss_axis_rx_len_check_if.slave  rx,
  pcie_ss_axis_rx_len_check_if.master tx,
  output logic                 err_short,
  output logic                 err_long,
  output logic [CNT_WIDTH-1:0] err_short_cnt,
  output logic [CNT_WIDTH-1:0] err_long_cnt
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PW         = DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;

  t_len_state    state, state_d;
  logic [7:0]    bcnt;
  logic [7:0]    exp_q;
  logic [7:0]    exp_sop;
  logic          rdy_en;
  logic          skid_in_ready;
  logic          rx_hs;
  logic          force_last;
  logic          short_d;
  logic          long_d;
  logic [PW-1:0] skid_in;
  logic [PW-1:0] skid_out;

  assign exp_sop  = exp_beats(rx.tdata[LEN_MSB:LEN_LSB], rx.tdata[FMT_DATA_BIT], DATA_WIDTH);
  assign rx.tready = rdy_en && ((state == DRAIN) || skid_in_ready);
  assign rx_hs    = rx.tvalid && rx.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SOP;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    force_last = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    if (rx_hs) begin
      case (state)
        SOP: begin
          if (exp_sop == 8'd1) begin
            force_last = 1'b1;
            if (!rx.tlast) begin
              long_d  = 1'b1;
              state_d = DRAIN;
            end
          end else if (rx.tlast) begin
            short_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (bcnt + 8'd1 == exp_q) begin
            force_last = 1'b1;
            if (rx.tlast) begin
              state_d = SOP;
            end else begin
              long_d  = 1'b1;
              state_d = DRAIN;
            end
          end else if (rx.tlast) begin
            short_d = 1'b1;
            state_d = SOP;
          end
        end
        DRAIN: begin
          if (rx.tlast) begin
            state_d = SOP;
          end
        end
        default: state_d = SOP;
      endcase
    end
  end

  // rdy_en holds off upstream for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en        <= 1'b0;
      bcnt          <= 8'd0;
      exp_q         <= 8'd0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_short_cnt <= '0;
      err_long_cnt  <= '0;
    end else begin
      rdy_en    <= 1'b1;
      err_short <= short_d;
      err_long  <= long_d;
      if (rx_hs) begin
        if (state == SOP) begin
          bcnt  <= 8'd1;
          exp_q <= exp_sop;
        end else begin
          bcnt <= bcnt + 8'd1;
        end
      end
      if (err_short && (err_short_cnt != '1)) begin
        err_short_cnt <= err_short_cnt + 1'b1;
      end
      if (err_long && (err_long_cnt != '1)) begin
        err_long_cnt <= err_long_cnt + 1'b1;
      end
    end
  end

  assign skid_in = {rx.tlast | force_last, rx.tuser, rx.tkeep, rx.tdata};

  pcie_ss_axis_rx_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rx.tvalid && rdy_en && (state != DRAIN)),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in),
    .out_valid (tx.tvalid),
    .out_ready (tx.tready),
    .out_data  (skid_out)
  );

  assign {tx.tlast, tx.tuser, tx.tkeep, tx.tdata} = skid_out;

endmodule

// File: tb/tb_pcie_ss_axis_rx_len_check.sv
// tb/tb_pcie_ss_axis_rx_len_check.sv - randomized and directed self-checking bench for the RX length checker
module tb_pcie_ss_axis_rx_len_check;
  import pcie_ss_rx_len_pkg::*;

  localparam int DW = 512;
  localparam int TW = 10;
  localparam int CW = 16;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_ss_axis_rx_len_check_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) rx_if ();
  pcie_ss_axis_rx_len_check_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) tx_if ();

  logic          err_short;
  logic          err_long;
  logic [CW-1:0] err_short_cnt;
  logic [CW-1:0] err_long_cnt;

  pcie_ss_axis_rx_len_check #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx_if),
    .tx            (tx_if),
    .err_short     (err_short),
    .err_long      (err_long),
    .err_short_cnt (err_short_cnt),
    .err_long_cnt  (err_long_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [TW-1:0] u;
    logic          l;
  } beat_t;

  beat_t expq[$];
  int n_tests = 0;
  int n_fail = 0;
  int m_short = 0;
  int m_long = 0;
  int seen_short = 0;
  int seen_long = 0;
  int rx_acc = 0;
  int tready_mode = 0;
  bit stall_prev = 1'b0;
  beat_t held;

  function automatic int m_exp(input int len, input bit has, input int dw);
    int pay;
    pay = has ? ((len == 0) ? 1024 * 4 : len * 4) : 0;
    return (32 + pay + dw / 8 - 1) / (dw / 8);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t make_beat(input int i, input int len, input bit has, input bit last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
    for (int w = 0; w < KW / 32; w++) b.k[w*32 +: 32] = $urandom;
    b.u = TW'($urandom);
    b.l = last;
    if (i == 0) begin
      b.d[9:0] = 10'(len);
      b.d[30]  = has;
    end
    return b;
  endfunction

  task automatic compare_loop();
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_short || err_long) chk("err_exclusive", 64'(err_short & err_long), 64'd0);
        seen_short += int'(err_short);
        seen_long  += int'(err_long);
        if (stall_prev) begin
          chk("stall_valid", 64'(tx_if.tvalid), 64'd1);
          chk_w("stall_data", tx_if.tdata, held.d);
          chk("stall_last", 64'(tx_if.tlast), 64'(held.l));
        end
        if (tx_if.tvalid && tx_if.tready) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = expq.pop_front();
            chk_w("tx_tdata", tx_if.tdata, e.d);
            chk("tx_tkeep", 64'(tx_if.tkeep), 64'(e.k));
            chk("tx_tuser", 64'(tx_if.tuser), 64'(e.u));
            chk("tx_tlast", 64'(tx_if.tlast), 64'(e.l));
          end
        end
        stall_prev = tx_if.tvalid && !tx_if.tready;
        held.d = tx_if.tdata;
        held.l = tx_if.tlast;
        if (rx_if.tvalid && rx_if.tready) rx_acc++;
      end else begin
        stall_prev = 1'b0;
      end
    end
  endtask

  task automatic tready_loop();
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: tx_if.tready = 1'b1;
        1: tx_if.tready = ~tx_if.tready;
        default: tx_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic send_beat(input beat_t b, input bit gap);
    bit hs;
    int t;
    if (gap) begin
      rx_if.tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = b.d;
    rx_if.tkeep  = b.k;
    rx_if.tuser  = b.u;
    rx_if.tlast  = b.l;
    t = 0;
    hs = 1'b0;
    while (!hs && t < 500) begin
      @(negedge clk);
      hs = rx_if.tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) chk("rx_handshake_timeout", 64'd1, 64'd0);
    rx_if.tvalid = 1'b0;
  endtask

  task automatic send_tlp(input int len, input bit has, input int n, input bit gaps);
    int e;
    int fwd;
    beat_t b;
    e = m_exp(len, has, DW);
    fwd = (n < e) ? n : e;
    if (n < e) m_short++;
    if (n > e) m_long++;
    for (int i = 0; i < n; i++) begin
      b = make_beat(i, len, has, i == n - 1);
      if (i < fwd) begin
        beat_t x;
        x = b;
        x.l = (i == fwd - 1);
        expq.push_back(x);
      end
      send_beat(b, gaps);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc0;
    int len;
    int e;
    int n;
    bit has;
    beat_t b;
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tkeep  = '0;
    rx_if.tuser  = '0;
    rx_if.tlast  = 1'b0;
    tx_if.tready = 1'b1;
    fork
      compare_loop();
      tready_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_tvalid", 64'(tx_if.tvalid), 64'd0);
    chk("rst_rx_tready", 64'(rx_if.tready), 64'd0);
    chk("rst_short_cnt", 64'(err_short_cnt), 64'd0);
    chk("rst_long_cnt", 64'(err_long_cnt), 64'd0);
    rst_n = 1'b1;
    #2;
    chk("rx_tready_first_cycle", 64'(rx_if.tready), 64'd0);
    @(posedge clk);
    #1;
    chk("rx_tready_after", 64'(rx_if.tready), 64'd1);

    // model anchors against hand-computed beat counts
    chk("model_len16", 64'(m_exp(16, 1, 512)), 64'd2);
    chk("model_len8", 64'(m_exp(8, 1, 512)), 64'd1);
    chk("model_len0_512", 64'(m_exp(0, 1, 512)), 64'd65);
    chk("model_len0_1024", 64'(m_exp(0, 1, 1024)), 64'd33);
    chk("pkg_len0_1024", 64'(exp_beats(10'd0, 1'b1, 1024)), 64'd33);
    chk("pkg_len0_512", 64'(exp_beats(10'd0, 1'b1, 512)), 64'd65);

    send_tlp(16, 1, 2, 0);
    wait_idle();
    chk("t1_short_cnt", 64'(err_short_cnt), 64'd0);
    chk("t1_long_cnt", 64'(err_long_cnt), 64'd0);

    send_tlp(16, 1, 1, 0);
    wait_idle();
    chk("t2_short_cnt", 64'(err_short_cnt), 64'd1);
    chk("t2_short_pulses", 64'(seen_short), 64'd1);

    send_tlp(8, 1, 3, 0);
    send_tlp(16, 1, 2, 0);
    wait_idle();
    chk("t3_long_cnt", 64'(err_long_cnt), 64'd1);
    chk("t3_long_pulses", 64'(seen_long), 64'd1);
    chk("t3_short_cnt", 64'(err_short_cnt), 64'd1);

    send_tlp(1, 0, 1, 0);
    acc0 = rx_acc;
    send_tlp(0, 1, 65, 0);
    wait_idle();
    chk("t4_len0_beats", 64'(rx_acc - acc0), 64'd65);
    chk("t4_short_cnt", 64'(err_short_cnt), 64'd1);
    chk("t4_long_cnt", 64'(err_long_cnt), 64'd1);

    tready_mode = 1;
    for (int i = 0; i < 12; i++) send_tlp($urandom_range(0, 1023), 0, 1, 0);
    wait_idle();

    tready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      has = 1'($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
      e = m_exp(len, has, DW);
      n = e + $urandom_range(0, 4) - 2;
      if (n < 1) n = 1;
      send_tlp(len, has, n, 1);
    end
    tready_mode = 0;
    wait_idle();
    chk("tot_short_pulses", 64'(seen_short), 64'(m_short));
    chk("tot_long_pulses", 64'(seen_long), 64'(m_long));
    chk("tot_short_cnt", 64'(err_short_cnt), 64'(m_short));
    chk("tot_long_cnt", 64'(err_long_cnt), 64'(m_long));

    // reset during beat 2 of a 4-beat TLP
    b = make_beat(0, 56, 1, 0);
    expq.push_back(b);
    send_beat(b, 0);
    b = make_beat(1, 56, 1, 0);
    rx_if.tvalid = 1'b1;
    rx_if.tdata  = b.d;
    rx_if.tlast  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_tvalid", 64'(tx_if.tvalid), 64'd0);
    chk("mid_rst_tx_tlast", 64'(tx_if.tlast), 64'd0);
    chk("mid_rst_rx_tready", 64'(rx_if.tready), 64'd0);
    chk("mid_rst_short_cnt", 64'(err_short_cnt), 64'd0);
    chk("mid_rst_long_cnt", 64'(err_long_cnt), 64'd0);
    rx_if.tvalid = 1'b0;
    expq.delete();
    m_short = 0;
    m_long = 0;
    seen_short = 0;
    seen_long = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_tlp(16, 1, 2, 0);
    send_tlp(8, 1, 1, 0);
    wait_idle();
    chk("post_rst_short_cnt", 64'(err_short_cnt), 64'd0);
    chk("post_rst_long_cnt", 64'(err_long_cnt), 64'd0);
    chk("post_rst_pulses", 64'(seen_short + seen_long), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
